// File: rtl/program_loader.sv
// program_loader: boot-time loader that streams 32-bit instruction words into
// instruction memory from address 0 and holds the CPU in reset until the last
// word has been written and a short settle interval has elapsed.
//
// Handshake: a word is consumed on a rising edge where in_valid_i and
// in_ready_o are both high; in_valid_i without in_ready_o consumes nothing and
// the upstream must hold in_data_i/in_last_i stable. in_ready_o is
// combinational and high only in the LOAD state.
module program_loader #(
    parameter int ADDR_WIDTH  = 10,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  in_valid_i,
    input  logic [31:0]           in_data_i,
    input  logic                  in_last_i,
    input  logic                  reload_i,
    output logic                  in_ready_o,
    output logic                  imem_we_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    output logic [31:0]           imem_wdata_o,
    output logic                  cpu_reset_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [ADDR_WIDTH:0]   loaded_count_o,
    output logic [1:0]            state_o
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    // Count value meaning "memory full"; the word pointer is the low bits of
    // the count, so the last legal address is FULL-1.
    localparam logic [ADDR_WIDTH:0] FULL      = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] LAST_PTR  = FULL - {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [3:0]          HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [3:0]            hold_q, hold_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  cpu_reset_q, cpu_reset_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  accept;

    assign in_ready_o     = (state_q == ST_LOAD);
    assign accept         = in_ready_o && in_valid_i;
    assign imem_we_o      = we_q;
    assign imem_addr_o    = addr_q;
    assign imem_wdata_o   = wdata_q;
    assign cpu_reset_o    = cpu_reset_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign loaded_count_o = cnt_q;
    assign state_o        = state_q;

    // State and output registers; async reset puts the CPU back in reset.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= ST_LOAD;
            cnt_q       <= '0;
            hold_q      <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    // Next-state logic: load words, settle, run, or latch overflow.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_reset_d = cpu_reset_q;
        done_d      = done_q;
        error_d     = error_q;
        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q[ADDR_WIDTH-1:0];
                    wdata_d = in_data_i;
                    if (cnt_q != FULL) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                    if (in_last_i) begin
                        state_d = ST_HOLD;
                        hold_d  = '0;
                    end else if (cnt_q == LAST_PTR) begin
                        // Memory is full and the program has not ended: the
                        // word is still written but the load is abandoned.
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d     = ST_RUN;
                    cpu_reset_d = 1'b0;
                    done_d      = 1'b1;
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            ST_RUN, ST_ERROR: begin
                if (reload_i) begin
                    state_d     = ST_LOAD;
                    cnt_d       = '0;
                    cpu_reset_d = 1'b1;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

endmodule
